rx_substate_monitor: RTL and testbench

- Parametrised successor to the master RX LTSSM substate monitor.
- On each substate request it counts consecutive good ordered sets per active lane and times the substate with an internal ms-tick timer.
- It reports success or failure plus the next substate to the main LTSSM.
- Adds arbitrary lane counts, per-lane consecutive counting with mismatch clear, abort on new request, and bounded recovery retries.

---
 rtl/rx_substate_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_rx_substate_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_substate_monitor.sv
// RX LTSSM substate monitor: counts consecutive good ordered sets per active lane,
// times the substate against a ms budget and reports success/failure plus the next substate.
module rx_substate_monitor #(
   parameter int MAXLANES  = 16,
   parameter int CNT_W     = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic [4:0]          substate,
   input  logic [5:0]          numberOfDetectedLanes,
   input  logic [MAXLANES-1:0] laneMatch,
   input  logic [MAXLANES-1:0] laneMismatch,
   input  logic                msTick,
   input  logic                rxElectricalIdle,
   input  logic                rcvrCfgToIdle,
   input  logic [2:0]          trainToGen,
   output logic                busy,
   output logic [MAXLANES-1:0] osCheckerEnable,
   output logic                finish,
   output logic                failed,
   output logic [4:0]          exitTo,
   output logic [1:0]          retryCount
);

   localparam logic [4:0] S_DETECT_QUIET  = 5'd0;
   localparam logic [4:0] S_DETECT_ACTIVE = 5'd1;
   localparam logic [4:0] S_POLL_ACTIVE   = 5'd2;
   localparam logic [4:0] S_POLL_CFG      = 5'd3;
   localparam logic [4:0] S_LW_START      = 5'd4;
   localparam logic [4:0] S_LW_ACCEPT     = 5'd5;
   localparam logic [4:0] S_LN_WAIT       = 5'd6;
   localparam logic [4:0] S_LN_ACCEPT     = 5'd7;
   localparam logic [4:0] S_CFG_COMPLETE  = 5'd8;
   localparam logic [4:0] S_CFG_IDLE      = 5'd9;
   localparam logic [4:0] S_L0            = 5'd10;
   localparam logic [4:0] S_REC_LOCK      = 5'd11;
   localparam logic [4:0] S_REC_CFG       = 5'd12;
   localparam logic [4:0] S_REC_SPEED     = 5'd13;
   localparam logic [4:0] S_PHASE0        = 5'd14;
   localparam logic [4:0] S_PHASE1        = 5'd15;
   localparam logic [4:0] S_PHASE2        = 5'd16;
   localparam logic [4:0] S_PHASE3        = 5'd17;
   localparam logic [4:0] S_REC_IDLE      = 5'd18;

   // Common width so required counts up to 8 compare cleanly against narrow counters.
   localparam int CW = (CNT_W > 4) ? CNT_W : 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [4:0]       sub_q, sub_d;
   logic [3:0]       rq_q, rq_d;
   logic [5:0]       lim_q, lim_d;
   logic [5:0]       ms_q, ms_d;
   logic [CNT_W-1:0] cnt_q [MAXLANES];
   logic [CNT_W-1:0] cnt_d [MAXLANES];
   logic [4:0]       exit_q, exit_d;
   logic             failed_q, failed_d;
   logic [1:0]       retry_q, retry_d;

   logic [MAXLANES-1:0] mask;
   logic [3:0]          new_r;
   logic [5:0]          new_t;
   logic                accept, met, timeout, success;
   logic [4:0]          succ_exit;

   assign accept  = req && (substate != S_L0) && (substate <= S_REC_IDLE);
   assign timeout = (ms_q >= lim_q);

   always_comb begin
      for (int i = 0; i < MAXLANES; i++) begin
         mask[i] = (int'(numberOfDetectedLanes) <= MAXLANES) && (i < int'(numberOfDetectedLanes));
      end
   end

   // Required consecutive-OS count and ms budget for the requested substate.
   always_comb begin
      new_r = 4'd0;
      new_t = 6'd0;
      case (substate)
         S_DETECT_QUIET:                 new_t = 6'd12;
         S_DETECT_ACTIVE:                new_t = 6'd0;
         S_POLL_ACTIVE, S_CFG_COMPLETE: begin new_r = 4'd8; new_t = 6'd24; end
         S_LW_START, S_LW_ACCEPT, S_LN_ACCEPT,
         S_PHASE0, S_PHASE1, S_PHASE2, S_PHASE3: begin new_r = 4'd2; new_t = 6'd24; end
         S_LN_WAIT, S_CFG_IDLE:          begin new_r = 4'd2; new_t = 6'd2;  end
         S_POLL_CFG, S_REC_LOCK, S_REC_CFG: begin new_r = 4'd8; new_t = 6'd48; end
         S_REC_IDLE:                     begin new_r = 4'd8; new_t = 6'd2;  end
         S_REC_SPEED:                    begin new_r = 4'd1; new_t = 6'd1;  end
         default: ;
      endcase
   end

   always_comb begin
      met = |mask;
      for (int i = 0; i < MAXLANES; i++) begin
         if (mask[i] && (CW'(cnt_q[i]) < CW'(rq_q))) met = 1'b0;
      end
   end

   always_comb begin
      case (sub_q)
         S_DETECT_QUIET:  success = rxElectricalIdle || timeout;
         S_DETECT_ACTIVE: success = timeout;
         S_REC_SPEED:     success = met && timeout;
         default:         success = met && !timeout;
      endcase
   end

   always_comb begin
      succ_exit = sub_q + 5'd1;
      if (rcvrCfgToIdle && (sub_q == S_REC_CFG))           succ_exit = S_REC_IDLE;
      else if (sub_q == S_PHASE3)                          succ_exit = S_REC_LOCK;
      else if (sub_q == S_REC_IDLE)                        succ_exit = S_L0;
      else if ((sub_q == S_REC_SPEED) && (trainToGen != 3'd3)) succ_exit = S_REC_LOCK;
   end

   // NOTE: every signal driven here gets a default first, so no path can hold a stale value (no latch).
   always_comb begin
      state_d  = state_q;
      sub_d    = sub_q;
      rq_d     = rq_q;
      lim_d    = lim_q;
      ms_d     = ms_q;
      cnt_d    = cnt_q;
      exit_d   = exit_q;
      failed_d = failed_q;
      retry_d  = retry_q;
      case (state_q)
         ST_IDLE, ST_COUNT: begin
            if (accept) begin
               // A new request in COUNT silently aborts the running substate.
               state_d = ST_COUNT;
               sub_d   = substate;
               rq_d    = new_r;
               lim_d   = new_t;
               ms_d    = '0;
               for (int i = 0; i < MAXLANES; i++) cnt_d[i] = '0;
            end else if (state_q == ST_COUNT) begin
               for (int i = 0; i < MAXLANES; i++) begin
                  if (mask[i]) begin
                     if (laneMismatch[i])                         cnt_d[i] = '0;
                     else if (laneMatch[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
               if (msTick && (ms_q != 6'h3f)) ms_d = ms_q + 6'd1;
               if (success) begin
                  state_d  = ST_DONE;
                  failed_d = 1'b0;
                  exit_d   = succ_exit;
                  retry_d  = '0;
               end else if (timeout) begin
                  state_d  = ST_DONE;
                  failed_d = 1'b1;
                  if ((sub_q >= S_REC_LOCK) && (sub_q <= S_REC_IDLE) && (int'(retry_q) < MAX_RETRY)) begin
                     exit_d  = S_REC_LOCK;
                     retry_d = retry_q + 2'd1;
                  end else begin
                     exit_d  = S_DETECT_QUIET;
                     retry_d = '0;
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         sub_q    <= '0;
         rq_q     <= '0;
         lim_q    <= '0;
         ms_q     <= '0;
         exit_q   <= '0;
         failed_q <= 1'b0;
         retry_q  <= '0;
         // NOTE: the lane counter array is reset explicitly; it is state the monitor must start clean.
         for (int i = 0; i < MAXLANES; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         sub_q    <= sub_d;
         rq_q     <= rq_d;
         lim_q    <= lim_d;
         ms_q     <= ms_d;
         exit_q   <= exit_d;
         failed_q <= failed_d;
         retry_q  <= retry_d;
         for (int i = 0; i < MAXLANES; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign busy            = (state_q != ST_IDLE);
   assign finish          = (state_q == ST_DONE);
   assign osCheckerEnable = (state_q == ST_COUNT) ? mask : '0;
   assign failed          = failed_q;
   assign exitTo          = exit_q;
   assign retryCount      = retry_q;

endmodule

// File: tb/tb_rx_substate_monitor.sv
// Randomised scoreboard bench for rx_substate_monitor: a rules-level model predicts each
// transaction's outcome, a separate monitor compares every finish pulse against the queue.
module tb_rx_substate_monitor;

   localparam int ML = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          req;
   logic [4:0]    substate;
   logic [5:0]    numberOfDetectedLanes;
   logic [ML-1:0] laneMatch, laneMismatch;
   logic          msTick, rxElectricalIdle, rcvrCfgToIdle;
   logic [2:0]    trainToGen;
   logic          busy, finish, failed;
   logic [ML-1:0] osCheckerEnable;
   logic [4:0]    exitTo;
   logic [1:0]    retryCount;

   always #5 clk = ~clk;

   rx_substate_monitor #(.MAXLANES(ML), .CNT_W(4), .MAX_RETRY(3)) dut (
      .clk(clk), .reset(reset), .req(req), .substate(substate),
      .numberOfDetectedLanes(numberOfDetectedLanes),
      .laneMatch(laneMatch), .laneMismatch(laneMismatch), .msTick(msTick),
      .rxElectricalIdle(rxElectricalIdle), .rcvrCfgToIdle(rcvrCfgToIdle),
      .trainToGen(trainToGen), .busy(busy), .osCheckerEnable(osCheckerEnable),
      .finish(finish), .failed(failed), .exitTo(exitTo), .retryCount(retryCount)
   );

   typedef struct {
      int failed;
      int exit_to;
      int retry;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   fin_seen = 0;
   int   model_retry = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Required consecutive count and ms budget, straight from the substate table.
   function automatic int req_count(input int s);
      case (s)
         2, 3, 8, 11, 12, 18:         return 8;
         4, 5, 6, 7, 9, 14, 15, 16, 17: return 2;
         13:                          return 1;
         default:                     return 0;
      endcase
   endfunction

   function automatic int ms_limit(input int s);
      case (s)
         0:                        return 12;
         2, 4, 5, 7, 8, 14, 15, 16, 17: return 24;
         6, 9, 18:                 return 2;
         3, 11, 12:                return 48;
         13:                       return 1;
         default:                  return 0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset && finish) begin
         fin_seen++;
         if (sb_q.size() == 0) check("unexpected_finish", 1, 0);
         else begin
            mon_e = sb_q.pop_front();
            check("failed", failed, mon_e.failed);
            check("exitTo", exitTo, mon_e.exit_to);
            check("retryCount", retryCount, mon_e.retry);
            check("busy_in_done", busy, 1);
         end
      end
   end

   task automatic idle_inputs();
      req = 0; laneMatch = '0; laneMismatch = '0; msTick = 0;
   endtask

   task automatic check_reset_values();
      check("rst_busy", busy, 0);
      check("rst_finish", finish, 0);
      check("rst_failed", failed, 0);
      check("rst_exitTo", exitTo, 0);
      check("rst_retry", retryCount, 0);
      check("rst_oce", osCheckerEnable, 0);
   endtask

   task automatic run_txn(input int sub, input int n, input int p_match, input int p_mis,
                          input int p_tick, input int tick_hold, input int ttg,
                          input bit rxidle, input bit cfgidle, input int abort_at,
                          input int abort_sub, input int reset_at);
      int cnt[ML];
      int ms, r, t, na, cur, fin0;
      bit met, tmo, succ, done;
      exp_t e;
      @(negedge clk);
      idle_inputs();
      numberOfDetectedLanes = 6'(n);
      trainToGen = 3'(ttg);
      rxElectricalIdle = rxidle;
      rcvrCfgToIdle = cfgidle;
      req = 1; substate = 5'(sub);
      cur = sub; ms = 0; r = req_count(cur); t = ms_limit(cur);
      na = (n >= 1 && n <= ML) ? n : 0;
      foreach (cnt[i]) cnt[i] = 0;
      done = 0; fin0 = fin_seen;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 0) begin
            check("busy_count", busy, 1);
            check("osCheckerEnable", osCheckerEnable, (longint'(1) << na) - 1);
         end
         if (k == reset_at) begin
            reset = 0;
            @(negedge clk);
            check_reset_values();
            reset = 1;
            model_retry = 0;
            return;
         end
         if (k == abort_at) begin
            req = 1; substate = 5'(abort_sub);
            cur = abort_sub; ms = 0; r = req_count(cur); t = ms_limit(cur);
            foreach (cnt[i]) cnt[i] = 0;
            continue;
         end
         met = (na > 0);
         for (int i = 0; i < na; i++) if (cnt[i] < r) met = 0;
         tmo = (ms >= t);
         case (cur)
            0:       succ = rxidle || tmo;
            1:       succ = tmo;
            13:      succ = met && tmo;
            default: succ = met && !tmo;
         endcase
         if (succ || tmo) begin
            if (succ) begin
               e.failed = 0;
               if (cfgidle && cur == 12)      e.exit_to = 18;
               else if (cur == 17)            e.exit_to = 11;
               else if (cur == 18)            e.exit_to = 10;
               else if (cur == 13 && ttg != 3) e.exit_to = 11;
               else                           e.exit_to = cur + 1;
               model_retry = 0;
            end else begin
               e.failed = 1;
               if (cur >= 11 && cur <= 18 && model_retry < 3) begin
                  e.exit_to = 11; model_retry++;
               end else begin
                  e.exit_to = 0; model_retry = 0;
               end
            end
            e.retry = model_retry;
            fin0 = fin_seen;
            sb_q.push_back(e);
            done = 1;
         end else begin
            for (int i = 0; i < ML; i++) begin
               if (i < na) begin
                  laneMatch[i]    = ($urandom_range(99) < p_match);
                  laneMismatch[i] = ($urandom_range(99) < p_mis);
                  if (laneMismatch[i])     cnt[i] = 0;
                  else if (laneMatch[i])   cnt[i] = (cnt[i] < 15) ? cnt[i] + 1 : 15;
               end else begin
                  laneMatch[i]    = $urandom_range(1);
                  laneMismatch[i] = $urandom_range(1);
               end
            end
            if (k >= tick_hold && $urandom_range(99) < p_tick) begin
               msTick = 1; ms++;
            end
         end
      end
      if (!done) begin
         check("txn_cycle_bound", 0, 1);
         return;
      end
      for (int w = 0; w < 5 && fin_seen == fin0; w++) begin
         @(negedge clk); #1;
      end
      if (fin_seen == fin0) check("finish_timeout", 0, 1);
   endtask

   task automatic invalid_req(input int sub);
      @(negedge clk);
      idle_inputs();
      req = 1; substate = 5'(sub); numberOfDetectedLanes = 6'd4;
      @(negedge clk);
      req = 0;
      check("invalid_req_busy", busy, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, as;
      reset = 0; idle_inputs(); substate = '0; numberOfDetectedLanes = '0;
      rxElectricalIdle = 0; rcvrCfgToIdle = 0; trainToGen = '0;
      repeat (2) @(negedge clk);
      check_reset_values();
      reset = 1;

      // pollingActive, all matches, no ticks -> success to pollingConfiguration
      run_txn(2, 4, 100, 0, 0, 0, 2, 0, 0, -1, 0, -1);
      // configurationIdle starved of matches -> timeout to detectQuiet
      run_txn(9, 4, 0, 0, 100, 0, 2, 0, 0, -1, 0, -1);
      // recoveryRcvrLock timeouts walk the retry budget then fall back
      repeat (4) run_txn(11, 4, 0, 0, 100, 0, 2, 0, 0, -1, 0, -1);
      // recoverySpeed: trainToGen picks the exit
      run_txn(13, 4, 100, 0, 100, 3, 2, 0, 0, -1, 0, -1);
      run_txn(13, 4, 100, 0, 100, 3, 3, 0, 0, -1, 0, -1);
      // counters must saturate, not wrap, over 20 matches
      run_txn(13, 16, 100, 0, 100, 20, 3, 0, 0, -1, 0, -1);
      // abort pollingActive with detectActive after 5 matches
      run_txn(2, 4, 100, 0, 0, 0, 2, 0, 0, 5, 1, -1);
      // exit priority cases
      run_txn(0, 4, 50, 0, 20, 0, 2, 1, 0, -1, 0, -1);
      run_txn(12, 2, 100, 0, 0, 0, 2, 0, 1, -1, 0, -1);
      run_txn(18, 2, 100, 0, 0, 0, 2, 0, 0, -1, 0, -1);
      run_txn(17, 3, 100, 0, 0, 0, 2, 0, 0, -1, 0, -1);
      invalid_req(10);
      invalid_req(19);
      invalid_req(31);
      // reset mid-COUNT, then empty lane masks
      run_txn(2, 4, 50, 0, 20, 0, 2, 0, 0, -1, 0, 3);
      run_txn(15, 0, 100, 0, 100, 0, 2, 0, 0, -1, 0, -1);
      run_txn(4, 17, 100, 0, 100, 0, 2, 0, 0, -1, 0, -1);
      run_txn(5, 63, 100, 0, 100, 0, 2, 0, 0, -1, 0, -1);
      run_txn(7, 16, 80, 5, 30, 0, 2, 0, 0, -1, 0, -1);

      repeat (60) begin
         s  = $urandom_range(18); if (s == 10) s = 11;
         as = $urandom_range(18); if (as == 10) as = 9;
         run_txn(s, $urandom_range(20), 40 + $urandom_range(60), $urandom_range(15),
                 5 + $urandom_range(35), $urandom_range(10), $urandom_range(7),
                 ($urandom_range(3) == 0), $urandom_range(1),
                 ($urandom_range(7) == 0) ? $urandom_range(6) : -1, as, -1);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
